// File: rtl/float_norm_seq.sv
`default_nettype none
// ============================================================================
// Module      : float_norm_seq
// Description : Sequential left-normalizer. Shifts one bit per clock until the
//               MSB is set, reporting mantissa, leading-one index and zero.
// Revision    : 1.0 - initial release
// ============================================================================
module float_norm_seq #(
  parameter int W  = 4,
  localparam int PW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  U,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  F,
  output logic [PW-1:0] P,
  output logic          zero
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_shift = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;

  localparam logic [PW-1:0] c_exp_top = PW'(W - 1);
  localparam logic [PW-1:0] c_exp_one = PW'(1);

  logic [1:0]    r_state;
  logic [W-1:0]  r_sreg;
  logic [PW-1:0] r_exp;
  logic [W-1:0]  r_f;
  logic [PW-1:0] r_p;
  logic          r_zero;

  logic          w_u_is_zero;
  logic          w_msb_set;

  assign w_u_is_zero = (U == '0);
  assign w_msb_set   = r_sreg[W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
      r_sreg  <= '0;
      r_exp   <= '0;
      r_f     <= '0;
      r_p     <= '0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_sreg <= U;
            r_exp  <= c_exp_top;
            if (w_u_is_zero) begin
              // Zero operand skips the shifter and completes immediately.
              r_f     <= '0;
              r_p     <= '0;
              r_zero  <= 1'b1;
              r_state <= c_st_done;
            end else begin
              r_state <= c_st_shift;
            end
          end
        end
        c_st_shift: begin
          if (w_msb_set) begin
            r_f     <= r_sreg;
            r_p     <= r_exp;
            r_zero  <= 1'b0;
            r_state <= c_st_done;
          end else begin
            // A nonzero operand needs at most W-1 shifts, so exp cannot wrap.
            r_sreg <= {r_sreg[W-2:0], 1'b0};
            r_exp  <= r_exp - c_exp_one;
          end
        end
        c_st_done: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign busy = (r_state != c_st_idle);
  assign done = (r_state == c_st_done);
  assign F    = r_f;
  assign P    = r_p;
  assign zero = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_float_norm_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_float_norm_seq
// Description : Directed, table-driven self-checking bench for float_norm_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_float_norm_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] U;
  logic       busy;
  logic       done;
  logic [3:0] F;
  logic [1:0] P;
  logic       zero;

  int n_pass;
  int n_total;

  float_norm_seq #(.W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .U     (U),
    .busy  (busy),
    .done  (done),
    .F     (F),
    .P     (P),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] u;
    int         lat;
    logic [3:0] f;
    logic [1:0] p;
    logic       z;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
  endtask

  // Issue one start; count edges after the accepting edge until done is seen.
  task automatic convert(input logic [3:0] u, output int lat, output bit timed_out);
    timed_out = 1'b0;
    @(negedge clk);
    start = 1'b1;
    U     = u;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!done) begin
      if (lat > 20) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    bit to;
    convert(v.u, lat, to);
    chk({tag, " timeout"}, int'(to), 0);
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " F"}, int'(F), int'(v.f));
    chk({tag, " P"}, int'(P), int'(v.p));
    chk({tag, " zero"}, int'(zero), int'(v.z));
    chk({tag, " busy_in_done"}, int'(busy), 1);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, int'(done), 0);
    chk({tag, " busy_after"}, int'(busy), 0);
    chk({tag, " F_held"}, int'(F), int'(v.f));
  endtask

  vec_t vecs[8];

  initial begin
    int   dcount;
    logic [3:0] f_seen;
    logic [1:0] p_seen;

    n_pass  = 0;
    n_total = 0;

    vecs[0] = '{4'b1010, 1, 4'b1010, 2'd3, 1'b0};
    vecs[1] = '{4'b0111, 2, 4'b1110, 2'd2, 1'b0};
    vecs[2] = '{4'b0001, 4, 4'b1000, 2'd0, 1'b0};
    vecs[3] = '{4'b0010, 3, 4'b1000, 2'd1, 1'b0};
    vecs[4] = '{4'b0000, 0, 4'b0000, 2'd0, 1'b1};
    vecs[5] = '{4'b1100, 1, 4'b1100, 2'd3, 1'b0};
    vecs[6] = '{4'b1111, 1, 4'b1111, 2'd3, 1'b0};
    vecs[7] = '{4'b0011, 3, 4'b1100, 2'd1, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    U     = 4'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset F", int'(F), 0);
    chk("reset P", int'(P), 0);
    chk("reset zero", int'(zero), 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // start held high while busy must be ignored.
    @(negedge clk);
    start = 1'b1;
    U     = 4'b0001;
    @(posedge clk);
    #1 U = 4'b1111;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    dcount = 0;
    f_seen = 4'b0;
    p_seen = 2'd3;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) begin
        dcount++;
        f_seen = F;
        p_seen = P;
      end
    end
    chk("ignore done_count", dcount, 1);
    chk("ignore F", int'(f_seen), 8);
    chk("ignore P", int'(p_seen), 0);

    // Abort mid-conversion with reset.
    @(negedge clk);
    start = 1'b1;
    U     = 4'b0001;
    @(posedge clk);
    #1 start = 1'b0;
    dcount = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    if (done) dcount++;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) dcount++;
      if (c == 0) begin
        chk("abort busy", int'(busy), 0);
        chk("abort F", int'(F), 0);
        chk("abort P", int'(P), 0);
        chk("abort zero", int'(zero), 0);
      end
    end
    chk("abort no_done", dcount, 0);
    run_vec('{4'b0100, 2, 4'b1000, 2'd2, 1'b0}, "post_abort");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
